// File: rtl/buyruk_onbellegi_if.sv
`default_nettype none
// ============================================================================
//  Module      : buyruk_onbellegi_if
//  Description : Fetch-side request/response and main-memory refill signals
//                of the instruction cache, bundled with cache/environment
//                modports. Suffixes are from the cache's point of view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface buyruk_onbellegi_if;
  // fetch stage side
  logic        getir_istek_i;
  logic [31:0] getir_ps_i;
  logic        getir_gecerli_o;
  logic [31:0] getir_deger_o;
  logic        getir_iptal_i;
  logic        temizle_i;
  // main memory side
  logic        bellek_istek_o;
  logic [31:0] bellek_adres_o;
  logic        bellek_gecerli_i;
  logic [31:0] bellek_deger_i;

  // the cache itself
  modport slave (
    input  getir_istek_i, getir_ps_i, getir_iptal_i, temizle_i,
    input  bellek_gecerli_i, bellek_deger_i,
    output getir_gecerli_o, getir_deger_o, bellek_istek_o, bellek_adres_o
  );

  // fetch stage plus memory arbiter
  modport master (
    output getir_istek_i, getir_ps_i, getir_iptal_i, temizle_i,
    output bellek_gecerli_i, bellek_deger_i,
    input  getir_gecerli_o, getir_deger_o, bellek_istek_o, bellek_adres_o
  );
endinterface
`default_nettype wire

// File: rtl/buyruk_onbellegi.sv
`default_nettype none
// ============================================================================
//  Module      : buyruk_onbellegi
//  Description : Direct-mapped read-only instruction cache. Hits answer one
//                cycle after acceptance; misses refill a whole line from word
//                0 upward, one memory request outstanding at a time.
//                Supports full invalidation and branch-redirect cancellation.
//  Revision    : 1.0 - initial release
// ============================================================================
module buyruk_onbellegi #(
  parameter int SATIR_SAYISI = 16,
  parameter int SATIR_KELIME = 4
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,   // asynchronous, active-low
  buyruk_onbellegi_if.slave bus
);

  localparam int O = $clog2(SATIR_KELIME);
  localparam int I = $clog2(SATIR_SAYISI);
  localparam int T = 30 - O - I;

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    DOLDUR = 2'd1,
    YANIT  = 2'd2
  } durum_e;

  durum_e              durum_q, durum_d;
  logic [29:0]         ps_q, ps_d;          // latched word address
  logic [O-1:0]        sayac_q, sayac_d;
  logic                iptal_q, iptal_d;
  logic                temizle_bekle_q, temizle_bekle_d;
  logic                gecerli_q, gecerli_d;
  logic [31:0]         deger_q, deger_d;
  logic                bellek_istek_q, bellek_istek_d;
  logic [31:0]         bellek_adres_q, bellek_adres_d;
  logic [SATIR_SAYISI-1:0] satir_gecerli_q;

  logic [T-1:0]        etiket_q [SATIR_SAYISI];
  logic [31:0]         veri_q   [SATIR_SAYISI*SATIR_KELIME];

  // incoming address split
  logic [O-1:0]        giris_ofset;
  logic [I-1:0]        giris_indeks;
  logic [T-1:0]        giris_etiket;
  logic                isabet;

  // latched address split
  logic [I-1:0]        kayit_indeks;
  logic [O-1:0]        kayit_ofset;
  logic [T-1:0]        kayit_etiket;
  logic [O-1:0]        sayac_art;
  logic                son_kelime;

  // array control strobes
  logic                hepsini_sil;
  logic                kelime_yaz;
  logic                satir_kur;

  assign giris_ofset  = bus.getir_ps_i[O+1:2];
  assign giris_indeks = bus.getir_ps_i[O+I+1:O+2];
  assign giris_etiket = bus.getir_ps_i[31:O+I+2];
  assign isabet       = satir_gecerli_q[giris_indeks] &&
                        (etiket_q[giris_indeks] == giris_etiket);

  assign kayit_ofset  = ps_q[O-1:0];
  assign kayit_indeks = ps_q[O+I-1:O];
  assign kayit_etiket = ps_q[29:O+I];
  assign sayac_art    = sayac_q + {{(O-1){1'b0}}, 1'b1};
  assign son_kelime   = (sayac_q == {O{1'b1}});

  // A redirect in the response cycle itself still suppresses the pulse.
  assign bus.getir_gecerli_o = gecerli_q & ~bus.getir_iptal_i;
  assign bus.getir_deger_o   = deger_q;
  assign bus.bellek_istek_o  = bellek_istek_q;
  assign bus.bellek_adres_o  = bellek_adres_q;

  // Next-state, refill sequencing and array strobes.
  always_comb begin
    durum_d         = durum_q;
    ps_d            = ps_q;
    sayac_d         = sayac_q;
    iptal_d         = iptal_q;
    temizle_bekle_d = temizle_bekle_q | bus.temizle_i;
    gecerli_d       = 1'b0;
    deger_d         = deger_q;
    bellek_istek_d  = bellek_istek_q;
    bellek_adres_d  = bellek_adres_q;
    hepsini_sil     = 1'b0;
    kelime_yaz      = 1'b0;
    satir_kur       = 1'b0;

    unique case (durum_q)
      BOSTA: begin
        iptal_d = 1'b0;
        if (temizle_bekle_q || bus.temizle_i) begin
          // invalidation takes the cycle; any request waits for the next one
          hepsini_sil     = 1'b1;
          temizle_bekle_d = 1'b0;
        end else if (bus.getir_istek_i) begin
          ps_d = bus.getir_ps_i[31:2];
          if (isabet) begin
            durum_d   = YANIT;
            gecerli_d = 1'b1;
            deger_d   = veri_q[{giris_indeks, giris_ofset}];
          end else begin
            durum_d        = DOLDUR;
            sayac_d        = '0;
            bellek_istek_d = 1'b1;
            bellek_adres_d = {giris_etiket, giris_indeks, {O{1'b0}}, 2'b00};
          end
        end
      end

      DOLDUR: begin
        if (bus.getir_iptal_i) begin
          iptal_d = 1'b1;
        end
        if (bus.bellek_gecerli_i) begin
          kelime_yaz = 1'b1;
          if (sayac_q == kayit_ofset) begin
            deger_d = bus.bellek_deger_i;
          end
          if (son_kelime) begin
            satir_kur      = 1'b1;
            bellek_istek_d = 1'b0;
            sayac_d        = '0;
            durum_d        = YANIT;
            gecerli_d      = ~(iptal_q | bus.getir_iptal_i);
          end else begin
            sayac_d        = sayac_art;
            bellek_adres_d = {kayit_etiket, kayit_indeks, sayac_art, 2'b00};
          end
        end
      end

      YANIT: begin
        if (bus.getir_iptal_i) begin
          iptal_d = 1'b1;
        end
        durum_d = BOSTA;
      end

      default: begin
        durum_d = BOSTA;
      end
    endcase
  end

  // Control registers and line valid bits.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q         <= BOSTA;
      ps_q            <= '0;
      sayac_q         <= '0;
      iptal_q         <= 1'b0;
      temizle_bekle_q <= 1'b0;
      gecerli_q       <= 1'b0;
      deger_q         <= '0;
      bellek_istek_q  <= 1'b0;
      bellek_adres_q  <= '0;
      satir_gecerli_q <= '0;
    end else begin
      durum_q         <= durum_d;
      ps_q            <= ps_d;
      sayac_q         <= sayac_d;
      iptal_q         <= iptal_d;
      temizle_bekle_q <= temizle_bekle_d;
      gecerli_q       <= gecerli_d;
      deger_q         <= deger_d;
      bellek_istek_q  <= bellek_istek_d;
      bellek_adres_q  <= bellek_adres_d;
      if (hepsini_sil) begin
        satir_gecerli_q <= '0;
      end else if (satir_kur) begin
        satir_gecerli_q[kayit_indeks] <= 1'b1;
      end
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (kelime_yaz) begin
      veri_q[{kayit_indeks, sayac_q}] <= bus.bellek_deger_i;
    end
    if (satir_kur) begin
      etiket_q[kayit_indeks] <= kayit_etiket;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_buyruk_onbellegi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_buyruk_onbellegi
//  Description : Self-checking bench for buyruk_onbellegi: directed cases
//                plus random fetches against a line-level cache model and a
//                memory responder with variable latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_buyruk_onbellegi;

  localparam int SATIR_SAYISI = 16;
  localparam int SATIR_KELIME = 4;
  localparam int SATIR_BAYT   = SATIR_KELIME * 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  buyruk_onbellegi_if bus ();

  buyruk_onbellegi #(
    .SATIR_SAYISI (SATIR_SAYISI),
    .SATIR_KELIME (SATIR_KELIME)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  int hata_sayisi   = 0;
  int kontrol_sayisi = 0;

  logic [31:0] ana_bellek [1024];
  logic [31:0] islem_q [$];      // memory addresses requested, in order
  int          lat_sabit = 1;    // 0 selects random latency 1..3

  bit          model_gecerli [SATIR_SAYISI];
  int unsigned model_satir   [SATIR_SAYISI];

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    kontrol_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic model_temizle();
    for (int i = 0; i < SATIR_SAYISI; i++) model_gecerli[i] = 1'b0;
  endtask

  // Main-memory responder: one outstanding read, data returned after latency.
  initial begin
    logic [31:0] adr;
    int g;
    bus.bellek_gecerli_i = 1'b0;
    bus.bellek_deger_i   = '0;
    forever begin
      @(negedge clk);
      bus.bellek_gecerli_i = 1'b0;
      if (bus.bellek_istek_o === 1'b1) begin
        adr = bus.bellek_adres_o;
        islem_q.push_back(adr);
        g = (lat_sabit > 0) ? lat_sabit : int'($urandom_range(1, 3));
        repeat (g - 1) @(negedge clk);
        bus.bellek_deger_i   = ana_bellek[adr[11:2]];
        bus.bellek_gecerli_i = 1'b1;
      end
    end
  end

  // mod: 0 plain, 1 redirect during refill, 2 invalidate during refill,
  //      3 invalidate in the same cycle as the request
  task automatic getir_yap(input logic [31:0] ps, input int mod);
    int unsigned satir;
    int          idx;
    bit          isabet;
    int          cyc, gec_cyc, vurus;
    bit          goruldu;
    logic [31:0] beklenen, alinan;
    if (mod == 3) model_temizle();
    satir    = ps / SATIR_BAYT;
    idx      = int'(satir % SATIR_SAYISI);
    isabet   = model_gecerli[idx] && (model_satir[idx] == satir);
    beklenen = ana_bellek[ps[11:2]];
    alinan   = '0;
    gec_cyc  = 0;
    vurus    = 0;
    goruldu  = 1'b0;
    islem_q.delete();
    @(negedge clk);
    bus.getir_istek_i = 1'b1;
    bus.getir_ps_i    = ps;
    if (mod == 3) bus.temizle_i = 1'b1;
    cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.temizle_i = 1'b0;
        if (mod == 1) begin
          bus.getir_istek_i = 1'b0;
          bus.getir_iptal_i = 1'b1;
        end
        if (mod == 2) bus.temizle_i = 1'b1;
      end
      if (cyc == 2) begin
        bus.getir_iptal_i = 1'b0;
        bus.temizle_i     = 1'b0;
      end
      if (bus.getir_gecerli_o === 1'b1) begin
        vurus++;
        if (!goruldu) begin
          goruldu           = 1'b1;
          gec_cyc           = cyc;
          alinan            = bus.getir_deger_o;
          bus.getir_istek_i = 1'b0;
          kontrol("bellek_bosta", {31'd0, bus.bellek_istek_o}, 32'd0);
        end
      end
      if (mod != 1 && goruldu && cyc > gec_cyc) break;
    end
    bus.getir_istek_i = 1'b0;
    if (mod == 1) begin
      kontrol("iptal_vurus", vurus, 0);
    end else begin
      kontrol("yanit_vurus", vurus, 1);
      kontrol("yanit_deger", alinan, beklenen);
      if (isabet) kontrol("isabet_gecikme", gec_cyc, 1);
    end
    if (isabet) begin
      kontrol("isabet_islem", islem_q.size(), 0);
    end else begin
      kontrol("dolum_islem", islem_q.size(), SATIR_KELIME);
      for (int k = 0; k < SATIR_KELIME && k < islem_q.size(); k++)
        kontrol("dolum_adres", islem_q[k], satir * SATIR_BAYT + 4 * k);
    end
    model_gecerli[idx] = 1'b1;
    model_satir[idx]   = satir;
    if (mod == 2) model_temizle();
  endtask

  initial begin
    bit sorun;
    for (int i = 0; i < 1024; i++) ana_bellek[i] = $urandom;
    ana_bellek[0] = 32'h11; ana_bellek[1] = 32'h22;
    ana_bellek[2] = 32'h33; ana_bellek[3] = 32'h44;
    model_temizle();
    bus.getir_istek_i = 1'b0;
    bus.getir_ps_i    = '0;
    bus.getir_iptal_i = 1'b0;
    bus.temizle_i     = 1'b0;
    rst_n = 1'b0;

    #2;
    kontrol("reset_gecerli", {31'd0, bus.getir_gecerli_o}, 32'd0);
    kontrol("reset_deger",   bus.getir_deger_o, 32'd0);
    kontrol("reset_istek",   {31'd0, bus.bellek_istek_o}, 32'd0);
    kontrol("reset_adres",   bus.bellek_adres_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // cold miss, hit, conflict eviction
    lat_sabit = 1;
    getir_yap(32'h0000_0004, 0);
    kontrol("soguk_deger", bus.getir_deger_o, 32'h22);
    getir_yap(32'h0000_000C, 0);
    kontrol("isabet_deger", bus.getir_deger_o, 32'h44);
    getir_yap(32'h0000_0100, 0);
    getir_yap(32'h0000_0000, 0);

    // redirect during refill, then the installed line hits
    getir_yap(32'h0000_0040, 1);
    getir_yap(32'h0000_0044, 0);

    // invalidate during refill, then a miss on the same line
    getir_yap(32'h0000_0080, 2);
    getir_yap(32'h0000_0084, 0);

    // invalidate together with a request on a resident line
    getir_yap(32'h0000_0200, 0);
    getir_yap(32'h0000_0200, 3);

    // asynchronous reset in the middle of a refill
    lat_sabit = 3;
    islem_q.delete();
    @(negedge clk);
    bus.getir_istek_i = 1'b1;
    bus.getir_ps_i    = 32'h0000_00C0;
    @(negedge clk);
    bus.getir_istek_i = 1'b0;
    kontrol("dolum_basladi", {31'd0, bus.bellek_istek_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    kontrol("ara_reset_istek", {31'd0, bus.bellek_istek_o}, 32'd0);
    kontrol("ara_reset_adres", bus.bellek_adres_o, 32'd0);
    kontrol("ara_reset_gecerli", {31'd0, bus.getir_gecerli_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sorun = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.getir_gecerli_o !== 1'b0 || bus.bellek_istek_o !== 1'b0) sorun = 1'b1;
    end
    kontrol("gec_yanit_yoksay", {31'd0, sorun}, 32'd0);
    model_temizle();
    lat_sabit = 1;
    getir_yap(32'h0000_00C0, 0);
    getir_yap(32'h0000_0004, 0);

    // random fetches with variable memory latency
    lat_sabit = 0;
    repeat (40) begin
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        bus.temizle_i = 1'b1;
        @(negedge clk);
        bus.temizle_i = 1'b0;
        model_temizle();
      end else begin
        getir_yap(32'($urandom_range(0, 127)) << 2, 0);
      end
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", hata_sayisi, kontrol_sayisi);
    $finish;
  end

endmodule
`default_nettype wire
